decoder_n_scan: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder; generalises the lab's 2-to-4 decoder.
- Direct mode: registered decode of select input S.
- Scan mode: autonomously walks the one-hot output through every line, holding each for DWELL cycles. Intended for multiplexed 7-seg digit strobing and LED row scanning in later labs.
- Sits between datapath/control logic and board-level enable lines.

---
 rtl/decoder_n_scan_if.sv | 15 +
 rtl/decoder_n_scan.sv | 107 ++++++++++
 tb/tb_decoder_n_scan.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/decoder_n_scan_if.sv
// Select/control and decoded-output bundle for decoder_n_scan.
// Master drives EN/MODE/S; slave (the decoder) drives O/IDX/WRAP.
interface decoder_n_scan_if #(
  parameter int N = 2
);
  logic              EN;
  logic              MODE;
  logic [N-1:0]      S;
  logic [2**N-1:0]   O;
  logic [N-1:0]      IDX;
  logic              WRAP;

  modport master (output EN, MODE, S, input O, IDX, WRAP);
  modport slave  (input EN, MODE, S, output O, IDX, WRAP);
endinterface

// File: rtl/decoder_n_scan.sv
// Registered N-to-2^N one-hot decoder with an auto-scan mode that dwells DWELL cycles per line.
// Define DECODER_ACTIVE_LOW_EN to drive O active-low (selected line 0, idle all ones).
module decoder_n_scan #(
  parameter int N     = 2,
  parameter int DWELL = 4
) (
  input  logic           CLK,
  input  logic           RST,
  decoder_n_scan_if.slave bus
);

  localparam int L  = 2**N;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

`ifdef DECODER_ACTIVE_LOW_EN
  localparam bit ACT_LOW = 1'b1;
`else
  localparam bit ACT_LOW = 1'b0;
`endif

  localparam logic [L-1:0]  O_IDLE   = ACT_LOW ? {L{1'b1}} : {L{1'b0}};
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [N-1:0]  IDX_ONE  = N'(32'd1);

  typedef enum logic [1:0] {ST_IDLE, ST_DIRECT, ST_SCAN} state_t;

  state_t          state_q, state_d;
  logic [L-1:0]    o_q, o_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wrap_q, wrap_d;

  // Output polarity is folded in here so O comes straight from a flop.
  function automatic logic [L-1:0] decode(input logic [N-1:0] idx);
    logic [L-1:0] v;
    v      = {L{1'b0}};
    v[idx] = 1'b1;
    return ACT_LOW ? ~v : v;
  endfunction

  // Next-state: mode transitions, dwell counting and index advance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (bus.EN) begin
      case (state_q)
        ST_IDLE, ST_DIRECT: begin
          state_d = bus.MODE ? ST_SCAN : ST_DIRECT;
          idx_d   = bus.S;
          cnt_d   = {CW{1'b0}};
        end
        ST_SCAN: begin
          if (!bus.MODE) begin
            state_d = ST_DIRECT;
            idx_d   = bus.S;
            cnt_d   = {CW{1'b0}};
          end else if (cnt_q == CNT_LAST) begin
            cnt_d  = {CW{1'b0}};
            idx_d  = idx_q + IDX_ONE;
            wrap_d = (idx_q == {N{1'b1}});
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = {N{1'b0}};
          cnt_d   = {CW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
    end
    if (state_d == ST_IDLE) begin
      o_d = O_IDLE;
    end else begin
      o_d = decode(idx_d);
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      o_q     <= O_IDLE;
      idx_q   <= {N{1'b0}};
      cnt_q   <= {CW{1'b0}};
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.O    = o_q;
  assign bus.IDX  = idx_q;
  assign bus.WRAP = wrap_q;

endmodule

// File: tb/tb_decoder_n_scan.sv
// Directed bench: N=2/DWELL=4 decoder for direct, scan, freeze and mode switching,
// plus an N=3/DWELL=1 decoder for per-cycle scanning and wrap.
module tb_decoder_n_scan;

`ifdef DECODER_ACTIVE_LOW_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_fail;

  decoder_n_scan_if #(.N(2)) ifa ();
  decoder_n_scan_if #(.N(3)) ifb ();

  decoder_n_scan #(.N(2), .DWELL(4)) dut_a (.CLK(CLK), .RST(RST), .bus(ifa));
  decoder_n_scan #(.N(3), .DWELL(1)) dut_b (.CLK(CLK), .RST(RST), .bus(ifb));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [3:0] ea(input logic [3:0] v);
    return AL ? ~v : v;
  endfunction

  function automatic logic [7:0] eb(input logic [7:0] v);
    return AL ? ~v : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] o, input logic [1:0] idx, input logic wrap);
    check({tag, ".O"},    32'(ifa.O),    32'(ea(o)));
    check({tag, ".IDX"},  32'(ifa.IDX),  32'(idx));
    check({tag, ".WRAP"}, 32'(ifa.WRAP), 32'(wrap));
  endtask

  logic [3:0] scan_o [14];
  logic [1:0] scan_i [14];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST = 1'b1;
    ifa.EN = 1'b0; ifa.MODE = 1'b0; ifa.S = 2'd0;
    ifb.EN = 1'b0; ifb.MODE = 1'b0; ifb.S = 3'd0;
    tick();
    check_a("reset", 4'b0000, 2'd0, 1'b0);
    check("reset_b.O", 32'(ifb.O), 32'(eb(8'h00)));

    // Release with EN=0: stays idle
    RST = 1'b0;
    tick(); tick();
    check_a("idle_en0", 4'b0000, 2'd0, 1'b0);

    // Direct decode
    ifa.EN = 1'b1; ifa.MODE = 1'b0;
    for (int s = 0; s < 4; s++) begin
      logic [3:0] one;
      one = 4'b0001;
      ifa.S = 2'(s);
      tick();
      check_a($sformatf("direct%0d", s), one << s, 2'(s), 1'b0);
    end

    // Scan from S=2; S ignored once scanning
    for (int k = 0; k < 14; k++) begin
      scan_i[k] = 2'((2 + k / 4) % 4);
      scan_o[k] = 4'b0001 << scan_i[k];
    end
    ifa.MODE = 1'b1; ifa.S = 2'd2;
    for (int k = 0; k < 14; k++) begin
      tick();
      ifa.S = 2'd0;
      check_a($sformatf("scan%0d", k), scan_o[k], scan_i[k], (k == 8) ? 1'b1 : 1'b0);
    end

    // Freeze with 0010 held two cycles so far
    ifa.EN = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_a($sformatf("freeze%0d", k), 4'b0010, 2'd1, 1'b0);
    end
    ifa.EN = 1'b1;
    tick(); check_a("resume0", 4'b0010, 2'd1, 1'b0);
    tick(); check_a("resume1", 4'b0010, 2'd1, 1'b0);
    tick(); check_a("resume2", 4'b0100, 2'd2, 1'b0);

    // Advance to IDX=3, then switch to direct
    tick(); tick(); tick(); tick();
    check_a("at_idx3", 4'b1000, 2'd3, 1'b0);
    ifa.MODE = 1'b0; ifa.S = 2'd1;
    tick(); check_a("to_direct", 4'b0010, 2'd1, 1'b0);

    // Back to scan from S=3 with a full dwell, then wrap
    ifa.MODE = 1'b1; ifa.S = 2'd3;
    for (int k = 0; k < 4; k++) begin
      tick(); check_a($sformatf("rescan%0d", k), 4'b1000, 2'd3, 1'b0);
    end
    tick(); check_a("rescan_wrap", 4'b0001, 2'd0, 1'b1);
    tick(); check_a("rescan_post", 4'b0001, 2'd0, 1'b0);

    // Asynchronous reset mid-scan
    #2 RST = 1'b1;
    #1 check_a("async_rst", 4'b0000, 2'd0, 1'b0);
    tick();
    RST = 1'b0;
    ifa.EN = 1'b0;

    // DWELL=1, N=3: advance every cycle, wrap on 7 -> 0
    check("idle_b.O", 32'(ifb.O), 32'(eb(8'h00)));
    ifb.EN = 1'b1; ifb.MODE = 1'b1; ifb.S = 3'd0;
    for (int k = 0; k < 10; k++) begin
      logic [7:0] one;
      one = 8'h01;
      tick();
      check($sformatf("b%0d.O", k),    32'(ifb.O),    32'(eb(one << (k % 8))));
      check($sformatf("b%0d.IDX", k),  32'(ifb.IDX),  32'(k % 8));
      check($sformatf("b%0d.WRAP", k), 32'(ifb.WRAP), (k == 8) ? 32'd1 : 32'd0);
    end
    check("a_frozen.O", 32'(ifa.O), 32'(ea(4'b0000)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
